// File: rtl/gray_monitor_pkg.sv
// Shared types and helpers for the gray-code monitor.
// GRAY_MON_SYNC_EN selects a two-flop input synchronizer (depth 2) instead of a single capture flop (depth 1).
package gray_monitor_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_VERIFY  = 2'd1,
        ST_LOCKED  = 2'd2
    } gm_state_e;

    // Helpers operate on a fixed maximum width; callers zero-extend narrower buses.
    localparam int MAX_BITS = 32;

`ifdef GRAY_MON_SYNC_EN
    localparam int SYNC_DEPTH = 2;
`else
    localparam int SYNC_DEPTH = 1;
`endif

    function automatic logic [MAX_BITS-1:0] gray2bin(input logic [MAX_BITS-1:0] g);
        logic [MAX_BITS-1:0] b;
        b[MAX_BITS-1] = g[MAX_BITS-1];
        for (int i = MAX_BITS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [7:0] popcount(input logic [MAX_BITS-1:0] v);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < MAX_BITS; i++) begin
            cnt = cnt + {7'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_code_monitor_gray_to_binary.sv
// Combinational gray-to-binary decode of a BITS-wide bus.
module gray_to_binary
    import gray_monitor_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] i_gray,
    output logic [BITS-1:0] o_bin
);

    assign o_bin = BITS'(gray2bin(MAX_BITS'(i_gray)));

endmodule

// File: rtl/gray_code_monitor.sv
// Gray-code bus monitor: samples, decodes and checks every change for a single-bit +1 step.
// GRAY_MON_SYNC_EN defined adds a two-flop synchronizer on gray_in; otherwise a single capture flop.
module gray_code_monitor
    import gray_monitor_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int ERR_BITS   = 16,
    parameter int LOCK_COUNT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BITS-1:0]     gray_in,
    input  logic                clear,
    output logic [BITS-1:0]     binary_out,
    output logic                step,
    output logic                error,
    output logic                locked,
    output logic [ERR_BITS-1:0] err_count
);

    localparam logic [7:0]          LOCK_TGT = 8'(LOCK_COUNT);
    localparam logic [1:0]          ACQ_LAST = 2'(SYNC_DEPTH);
    localparam logic [ERR_BITS-1:0] ERR_MAX  = {ERR_BITS{1'b1}};
    localparam logic [BITS-1:0]     BIN_ONE  = BITS'(1);

    logic [BITS-1:0]     r_sample;
    logic [BITS-1:0]     r_prev;
    logic [BITS-1:0]     r_bin;
    logic                r_step;
    logic                r_error;
    logic                r_locked;
    logic [ERR_BITS-1:0] r_err_count;
    logic [7:0]          r_good_run;
    logic [1:0]          r_acq_cnt;
    gm_state_e           r_state;

    logic [BITS-1:0]     w_sample_bin;
    logic [BITS-1:0]     w_prev_bin;
    logic                w_changed;
    logic                w_good;
    logic [ERR_BITS-1:0] w_err_inc;
    logic [7:0]          w_run_inc;

    gm_state_e           w_state_nxt;
    logic [BITS-1:0]     w_prev_nxt;
    logic [BITS-1:0]     w_bin_nxt;
    logic                w_step_nxt;
    logic                w_error_nxt;
    logic                w_locked_nxt;
    logic [ERR_BITS-1:0] w_err_nxt;
    logic [7:0]          w_run_nxt;
    logic [1:0]          w_acq_nxt;

`ifdef GRAY_MON_SYNC_EN
    logic [BITS-1:0] r_sync1;

    // Two-flop synchronizer; deliberately untouched by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= {BITS{1'b0}};
            r_sample <= {BITS{1'b0}};
        end else begin
            r_sync1  <= gray_in;
            r_sample <= r_sync1;
        end
    end
`else
    // Single capture register; deliberately untouched by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= {BITS{1'b0}};
        end else begin
            r_sample <= gray_in;
        end
    end
`endif

    gray_to_binary #(.BITS(BITS)) u_dec_sample (.i_gray(r_sample), .o_bin(w_sample_bin));
    gray_to_binary #(.BITS(BITS)) u_dec_prev   (.i_gray(r_prev),   .o_bin(w_prev_bin));

    assign w_changed = (r_sample != r_prev);
    assign w_good    = w_changed
                     && (popcount(MAX_BITS'(r_sample ^ r_prev)) == 8'd1)
                     && (w_sample_bin == (w_prev_bin + BIN_ONE));
    assign w_err_inc = (r_err_count == ERR_MAX) ? r_err_count : (r_err_count + {{(ERR_BITS-1){1'b0}}, 1'b1});
    assign w_run_inc = r_good_run + 8'd1;

    // Next-state and next-output decode; clear overrides any step evaluation.
    always_comb begin
        w_state_nxt  = r_state;
        w_prev_nxt   = r_prev;
        w_bin_nxt    = r_bin;
        w_step_nxt   = 1'b0;
        w_error_nxt  = 1'b0;
        w_locked_nxt = r_locked;
        w_err_nxt    = r_err_count;
        w_run_nxt    = r_good_run;
        w_acq_nxt    = r_acq_cnt;
        if (clear) begin
            w_state_nxt  = ST_ACQUIRE;
            w_locked_nxt = 1'b0;
            w_err_nxt    = {ERR_BITS{1'b0}};
            w_run_nxt    = 8'd0;
            w_acq_nxt    = 2'd0;
        end else begin
            case (r_state)
                ST_ACQUIRE: begin
                    if (r_acq_cnt == ACQ_LAST) begin
                        w_prev_nxt  = r_sample;
                        w_bin_nxt   = w_sample_bin;
                        w_run_nxt   = 8'd0;
                        w_acq_nxt   = 2'd0;
                        w_state_nxt = ST_VERIFY;
                    end else begin
                        w_acq_nxt = r_acq_cnt + 2'd1;
                    end
                end
                ST_VERIFY: begin
                    if (w_good) begin
                        w_step_nxt = 1'b1;
                        w_prev_nxt = r_sample;
                        w_bin_nxt  = w_sample_bin;
                        w_run_nxt  = w_run_inc;
                        if (w_run_inc == LOCK_TGT) begin
                            w_state_nxt  = ST_LOCKED;
                            w_locked_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_VERIFY;
                        end
                    end else if (w_changed) begin
                        w_error_nxt = 1'b1;
                        w_prev_nxt  = r_sample;
                        w_bin_nxt   = w_sample_bin;
                        w_err_nxt   = w_err_inc;
                        w_run_nxt   = 8'd0;
                    end else begin
                        w_state_nxt = ST_VERIFY;
                    end
                end
                ST_LOCKED: begin
                    if (w_good) begin
                        w_step_nxt = 1'b1;
                        w_prev_nxt = r_sample;
                        w_bin_nxt  = w_sample_bin;
                    end else if (w_changed) begin
                        w_error_nxt  = 1'b1;
                        w_prev_nxt   = r_sample;
                        w_bin_nxt    = w_sample_bin;
                        w_err_nxt    = w_err_inc;
                        w_run_nxt    = 8'd0;
                        w_locked_nxt = 1'b0;
                        w_state_nxt  = ST_VERIFY;
                    end else begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
                default: begin
                    w_state_nxt  = ST_ACQUIRE;
                    w_locked_nxt = 1'b0;
                    w_run_nxt    = 8'd0;
                    w_acq_nxt    = 2'd0;
                end
            endcase
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACQUIRE;
            r_prev      <= {BITS{1'b0}};
            r_bin       <= {BITS{1'b0}};
            r_step      <= 1'b0;
            r_error     <= 1'b0;
            r_locked    <= 1'b0;
            r_err_count <= {ERR_BITS{1'b0}};
            r_good_run  <= 8'd0;
            r_acq_cnt   <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_bin       <= w_bin_nxt;
            r_step      <= w_step_nxt;
            r_error     <= w_error_nxt;
            r_locked    <= w_locked_nxt;
            r_err_count <= w_err_nxt;
            r_good_run  <= w_run_nxt;
            r_acq_cnt   <= w_acq_nxt;
        end
    end

    assign binary_out = r_bin;
    assign step       = r_step;
    assign error      = r_error;
    assign locked     = r_locked;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_gray_code_monitor.sv
// Scoreboard bench for gray_code_monitor: directed gray vectors, expected pulses queued and checked by a monitor.
module tb_gray_code_monitor;
    import gray_monitor_pkg::*;

    localparam int BITS = 8;
    localparam int EB   = 2;

    typedef struct packed {
        logic          s;
        logic          e;
        logic [7:0]    b;
        logic          l;
        logic [EB-1:0] c;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [BITS-1:0] gray_in = 8'h00;
    logic            clear = 1'b0;
    logic [BITS-1:0] binary_out;
    logic            step;
    logic            error;
    logic            locked;
    logic [EB-1:0]   err_count;

    exp_t q[$];
    exp_t m_exp;
    int   n_checks = 0;
    int   n_pass   = 0;

    gray_code_monitor #(.BITS(BITS), .ERR_BITS(EB), .LOCK_COUNT(4)) dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clear(clear),
        .binary_out(binary_out), .step(step), .error(error),
        .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (step || error)) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'd0, step, error}, 32'd0);
            end else begin
                m_exp = q.pop_front();
                check("step",       {31'd0, step},        {31'd0, m_exp.s});
                check("error",      {31'd0, error},       {31'd0, m_exp.e});
                check("binary_out", {24'd0, binary_out},  {24'd0, m_exp.b});
                check("locked",     {31'd0, locked},      {31'd0, m_exp.l});
                check("err_count",  {30'd0, err_count},   {30'd0, m_exp.c});
            end
        end
    end

    task automatic settle();
        repeat (16) @(negedge clk);
        check("pending", q.size(), 32'd0);
    endtask

    task automatic drive(input logic [7:0] g, input logic s, input logic e,
                         input logic [7:0] b, input logic l, input logic [EB-1:0] c);
        @(negedge clk);
        gray_in = g;
        if (s || e) q.push_back('{s: s, e: e, b: b, l: l, c: c});
        settle();
    endtask

    task automatic check_idle(input string tag, input logic [7:0] b, input logic l, input logic [EB-1:0] c);
        check({tag, "_bin"},    {24'd0, binary_out},     {24'd0, b});
        check({tag, "_locked"}, {31'd0, locked},         {31'd0, l});
        check({tag, "_errcnt"}, {30'd0, err_count},      {30'd0, c});
        check({tag, "_pulse"},  {30'd0, step, error},    32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_idle("reset", 8'd0, 1'b0, 2'd0);
        rst_n = 1'b1;
        settle();

        // Basic count-up to lock
        drive(8'h01, 1'b1, 1'b0, 8'd1, 1'b0, 2'd0);
        drive(8'h03, 1'b1, 1'b0, 8'd2, 1'b0, 2'd0);
        drive(8'h02, 1'b1, 1'b0, 8'd3, 1'b0, 2'd0);
        drive(8'h06, 1'b1, 1'b0, 8'd4, 1'b1, 2'd0);

        // Re-acquire at bin 251 under a held clear, then lock up to 255 and wrap
        @(negedge clk); clear = 1'b1;
        @(negedge clk); gray_in = 8'h86;
        repeat (4) @(negedge clk);
        clear = 1'b0;
        settle();
        check_idle("reacq", 8'd251, 1'b0, 2'd0);
        drive(8'h82, 1'b1, 1'b0, 8'd252, 1'b0, 2'd0);
        drive(8'h83, 1'b1, 1'b0, 8'd253, 1'b0, 2'd0);
        drive(8'h81, 1'b1, 1'b0, 8'd254, 1'b0, 2'd0);
        drive(8'h80, 1'b1, 1'b0, 8'd255, 1'b1, 2'd0);
        drive(8'h00, 1'b1, 1'b0, 8'd0,   1'b1, 2'd0);
        drive(8'h01, 1'b1, 1'b0, 8'd1,   1'b1, 2'd0);
        drive(8'h03, 1'b1, 1'b0, 8'd2,   1'b1, 2'd0);
        drive(8'h02, 1'b1, 1'b0, 8'd3,   1'b1, 2'd0);

        // Multi-bit jump breaks lock, four good steps re-lock
        drive(8'h05, 1'b0, 1'b1, 8'd6,  1'b0, 2'd1);
        drive(8'h04, 1'b1, 1'b0, 8'd7,  1'b0, 2'd1);
        drive(8'h0C, 1'b1, 1'b0, 8'd8,  1'b0, 2'd1);
        drive(8'h0D, 1'b1, 1'b0, 8'd9,  1'b0, 2'd1);
        drive(8'h0F, 1'b1, 1'b0, 8'd10, 1'b1, 2'd1);

        // Jump to 0x03, then single-bit decrement is still an error
        drive(8'h03, 1'b0, 1'b1, 8'd2, 1'b0, 2'd2);
        drive(8'h01, 1'b0, 1'b1, 8'd1, 1'b0, 2'd3);

        // Clear, then saturation of a 2-bit error counter
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        settle();
        check_idle("clr", 8'd1, 1'b0, 2'd0);
        drive(8'h07, 1'b0, 1'b1, 8'd5, 1'b0, 2'd1);
        drive(8'h00, 1'b0, 1'b1, 8'd0, 1'b0, 2'd2);
        drive(8'h03, 1'b0, 1'b1, 8'd2, 1'b0, 2'd3);
        drive(8'h00, 1'b0, 1'b1, 8'd0, 1'b0, 2'd3);
        drive(8'h03, 1'b0, 1'b1, 8'd2, 1'b0, 2'd3);

        // Clear on the very edge a good step would be reported
        @(negedge clk);
        gray_in = 8'h02;
        repeat (SYNC_DEPTH) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        settle();
        check_idle("clr_step", 8'd3, 1'b0, 2'd0);
        drive(8'h06, 1'b1, 1'b0, 8'd4, 1'b0, 2'd0);

        // Asynchronous reset mid-run
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle("async_rst", 8'd0, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        check_idle("rst_hold", 8'd0, 1'b0, 2'd0);
        rst_n = 1'b1;
        settle();
        check_idle("post_rst", 8'd4, 1'b0, 2'd0);
        drive(8'h07, 1'b1, 1'b0, 8'd5, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
